// File: rtl/sitcpxg_rx_buf_reader.sv
// SiTCPXG RX buffer owner and reader: byte-enabled RAM writes in, left-justified 64-bit words out.
// Optional clear handshake (USER_CLR / SITCP_RX_CLR_REQ) is built only when SITCPXG_RXRD_CLR_EN is defined.
module sitcpxg_rx_buf_reader #(
    parameter int ADDR_W = 14
) (
    input  logic        XGMII_CLOCK,
    input  logic        RSTn,
    input  logic [15:0] SITCP_RX_WADR,
    input  logic [7:0]  SITCP_RX_WENB,
    input  logic [63:0] SITCP_RX_WDAT,
    output logic [15:0] SITCP_RX_RADR,
    output logic [15:0] SITCP_RX_SIZE,
    input  logic        SITCP_RX_CLR_ENB,
    output logic        SITCP_RX_CLR_REQ,
    input  logic        USER_CLR,
    output logic [63:0] OUT_D,
    output logic [3:0]  OUT_B,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] FILL
);
    localparam int WORD_W = ADDR_W - 3;
    localparam int DEPTH  = 1 << WORD_W;

    typedef enum logic [1:0] {ST_RUN, ST_CLR_WAIT, ST_CLR} state_t;

    logic [63:0]       r_mem [DEPTH];
    logic [63:0]       r_rdata;
    state_t            r_state;
    logic [ADDR_W-1:0] r_wptr, r_iptr, r_cptr, r_wend;
    logic              r_wv;
    logic              r_rd_v;
    logic [2:0]        r_rd_sh;
    logic [3:0]        r_rd_n;
    logic [63:0]       r_out_d, r_sk_d;
    logic [3:0]        r_out_b, r_sk_b;
    logic              r_out_v, r_sk_v;
    logic              r_clr_req;

    logic [WORD_W-1:0] w_wword, w_iword;
    logic [3:0]        w_wend_off, w_room, w_n;
    logic [ADDR_W-1:0] w_avail, w_fill;
    logic [1:0]        w_occ;
    logic              w_pop, w_issue, w_user_clr, w_clr_enb;
    logic [63:0]       w_mask, w_al;
    logic              w_unused;

`ifdef SITCPXG_RXRD_CLR_EN
    assign w_user_clr = USER_CLR;
    assign w_clr_enb  = SITCP_RX_CLR_ENB;
`else
    assign w_user_clr = 1'b0;
    assign w_clr_enb  = 1'b0;
`endif
    assign w_unused = &{1'b0, SITCP_RX_WADR, USER_CLR, SITCP_RX_CLR_ENB};

    assign w_wword = SITCP_RX_WADR[ADDR_W-1:3];
    assign w_iword = r_iptr[ADDR_W-1:3];
    assign w_avail = r_wptr - r_iptr;
    assign w_fill  = r_wptr - r_cptr;
    assign w_room  = 4'd8 - {1'b0, r_iptr[2:0]};
    assign w_n     = (w_avail < ADDR_W'(w_room)) ? w_avail[3:0] : w_room;
    assign w_pop   = r_out_v & OUT_READY;
    // Slots already claimed after this edge: both buffer entries plus the read in flight.
    assign w_occ   = {1'b0, r_out_v} + {1'b0, r_sk_v} + {1'b0, r_rd_v} - {1'b0, w_pop};
    assign w_issue = (r_state == ST_RUN) && (w_avail != '0) && (w_occ <= 2'd1);

    assign w_mask = ~64'd0 << {4'd8 - r_rd_n, 3'b000};
    assign w_al   = (r_rdata << {r_rd_sh, 3'b000}) & w_mask;

    // The last enabled lane (lowest WENB bit) marks the new write end within the word.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_wend_off = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (SITCP_RX_WENB[i]) w_wend_off = 4'(8 - i);
        end
    end

    // NOTE: the buffer RAM has no reset; pointers alone decide which contents are live.
    always_ff @(posedge XGMII_CLOCK) begin
        for (int b = 0; b < 8; b++) begin
            if (SITCP_RX_WENB[b]) r_mem[w_wword][8*b +: 8] <= SITCP_RX_WDAT[8*b +: 8];
        end
        if (w_issue) r_rdata <= r_mem[w_iword];
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (!RSTn) begin
            r_state   <= ST_RUN;
            r_wptr    <= '0;
            r_iptr    <= '0;
            r_cptr    <= '0;
            r_wend    <= '0;
            r_wv      <= 1'b0;
            r_rd_v    <= 1'b0;
            r_rd_sh   <= '0;
            r_rd_n    <= '0;
            r_out_d   <= '0;
            r_out_b   <= '0;
            r_out_v   <= 1'b0;
            r_sk_d    <= '0;
            r_sk_b    <= '0;
            r_sk_v    <= 1'b0;
            r_clr_req <= 1'b0;
        end else begin
            r_wv   <= |SITCP_RX_WENB;
            r_wend <= {w_wword, 3'b000} + ADDR_W'(w_wend_off);
            if (r_wv) r_wptr <= r_wend;

            r_rd_v  <= w_issue;
            r_rd_sh <= r_iptr[2:0];
            r_rd_n  <= w_n;
            if (w_issue) r_iptr <= r_iptr + ADDR_W'(w_n);
            if (w_pop)   r_cptr <= r_cptr + ADDR_W'(r_out_b);

            if (w_pop || !r_out_v) begin
                if (r_sk_v) begin
                    r_out_d <= r_sk_d;
                    r_out_b <= r_sk_b;
                    r_out_v <= 1'b1;
                    r_sk_v  <= r_rd_v;
                    r_sk_d  <= w_al;
                    r_sk_b  <= r_rd_n;
                end else begin
                    r_out_v <= r_rd_v;
                    if (r_rd_v) begin
                        r_out_d <= w_al;
                        r_out_b <= r_rd_n;
                    end
                end
            end else if (r_rd_v) begin
                r_sk_v <= 1'b1;
                r_sk_d <= w_al;
                r_sk_b <= r_rd_n;
            end

            // NOTE: non-blocking updates below override the datapath updates above in the CLR cycle.
            r_clr_req <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_user_clr && w_clr_enb) begin
                        r_state   <= ST_CLR;
                        r_clr_req <= 1'b1;
                    end else if (w_user_clr) begin
                        r_state <= ST_CLR_WAIT;
                    end
                end
                ST_CLR_WAIT: begin
                    if (w_clr_enb) begin
                        r_state   <= ST_CLR;
                        r_clr_req <= 1'b1;
                    end
                end
                ST_CLR: begin
                    r_state <= ST_RUN;
                    r_wptr  <= '0;
                    r_iptr  <= '0;
                    r_cptr  <= '0;
                    r_wv    <= 1'b0;
                    r_rd_v  <= 1'b0;
                    r_out_v <= 1'b0;
                    r_sk_v  <= 1'b0;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign OUT_D            = r_out_d;
    assign OUT_B            = r_out_b;
    assign OUT_VALID        = r_out_v;
    assign SITCP_RX_RADR    = 16'(r_cptr);
    assign FILL             = 16'(w_fill);
    assign SITCP_RX_SIZE    = 16'((1 << ADDR_W) - 16);
    assign SITCP_RX_CLR_REQ = r_clr_req;

endmodule

// File: tb/tb_sitcpxg_rx_buf_reader.sv
// Randomized bench for sitcpxg_rx_buf_reader against a byte-stream reference model.
// Clear-handshake tests run only when SITCPXG_RXRD_CLR_EN is defined.
module tb_sitcpxg_rx_buf_reader;
    localparam int ADDR_W = 14;
    localparam int SPACE  = (1 << ADDR_W) - 16;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic [15:0] SITCP_RX_WADR = '0;
    logic [7:0]  SITCP_RX_WENB = '0;
    logic [63:0] SITCP_RX_WDAT = '0;
    logic [15:0] SITCP_RX_RADR;
    logic [15:0] SITCP_RX_SIZE;
    logic        SITCP_RX_CLR_ENB = 1'b0;
    logic        SITCP_RX_CLR_REQ;
    logic        USER_CLR = 1'b0;
    logic [63:0] OUT_D;
    logic [3:0]  OUT_B;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] FILL;

    always #5 clk = ~clk;

    sitcpxg_rx_buf_reader #(.ADDR_W(ADDR_W)) dut (
        .XGMII_CLOCK     (clk),
        .RSTn            (RSTn),
        .SITCP_RX_WADR   (SITCP_RX_WADR),
        .SITCP_RX_WENB   (SITCP_RX_WENB),
        .SITCP_RX_WDAT   (SITCP_RX_WDAT),
        .SITCP_RX_RADR   (SITCP_RX_RADR),
        .SITCP_RX_SIZE   (SITCP_RX_SIZE),
        .SITCP_RX_CLR_ENB(SITCP_RX_CLR_ENB),
        .SITCP_RX_CLR_REQ(SITCP_RX_CLR_REQ),
        .USER_CLR        (USER_CLR),
        .OUT_D           (OUT_D),
        .OUT_B           (OUT_B),
        .OUT_VALID       (OUT_VALID),
        .OUT_READY       (OUT_READY),
        .FILL            (FILL)
    );

    int          n_checks = 0;
    int          n_bad    = 0;
    logic [7:0]  exp_q[$];
    int          b_hist[$];
    int          wr_bytes, rd_bytes, wa;
    logic        prev_stall;
    logic [63:0] prev_d;
    logic [3:0]  prev_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        b_hist.delete();
        wr_bytes   = 0;
        rd_bytes   = 0;
        wa         = 0;
        prev_stall = 1'b0;
    endtask

    function automatic int room();
        return SPACE - (wr_bytes - rd_bytes);
    endfunction

    // Called at a falling edge: check outputs, model the coming handshake, drive the next write.
    task automatic step(input logic [7:0] wenb, input logic [63:0] wdat, input logic rdy);
        logic [63:0] e;
        int          n;
        logic        ok;
        if (prev_stall) begin
            check("hold_valid", 64'(OUT_VALID), 64'd1);
            check("hold_d", OUT_D, prev_d);
            check("hold_b", 64'(OUT_B), 64'(prev_b));
        end
        check("radr", 64'(SITCP_RX_RADR), 64'(rd_bytes & AMASK));
        check("fill_le_size", 64'(int'(FILL) <= SPACE), 64'd1);
        OUT_READY = rdy;
        if (OUT_VALID && rdy) begin
            n  = int'(OUT_B);
            b_hist.push_back(n);
            ok = (n >= 1) && (n <= 8) && (n <= exp_q.size());
            check("out_b_legal", 64'(ok), 64'd1);
            e = '0;
            for (int i = 0; i < n && i < 8 && exp_q.size() > 0; i++) e[63-8*i -: 8] = exp_q.pop_front();
            check("out_d", OUT_D, e);
            rd_bytes += n;
        end
        prev_stall    = OUT_VALID && !rdy;
        prev_d        = OUT_D;
        prev_b        = OUT_B;
        SITCP_RX_WADR = 16'(wa);
        SITCP_RX_WENB = wenb;
        SITCP_RX_WDAT = wdat;
        for (int l = 0; l < 8; l++) begin
            if (wenb[7-l]) begin
                exp_q.push_back(wdat[63-8*l -: 8]);
                wr_bytes++;
            end
        end
        wa = (wa + $countones(wenb)) & AMASK;
        @(negedge clk);
    endtask

    task automatic wr_step(input int k_req, input logic rdy);
        int         lane, k;
        logic [7:0] wenb;
        lane = wa & 7;
        k    = k_req;
        if (k > 8 - lane) k = 8 - lane;
        if (k > room())   k = room();
        wenb = '0;
        for (int l = lane; l < lane + k; l++) wenb[7-l] = 1'b1;
        step(wenb, {$urandom, $urandom}, rdy);
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) step(8'h00, 64'd0, rdy);
    endtask

    task automatic drain(input string tag, input int max_cycles, input logic rnd);
        int c = 0;
        while (rd_bytes != wr_bytes && c < max_cycles) begin
            step(8'h00, 64'd0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            c++;
        end
        check(tag, 64'(rd_bytes), 64'(wr_bytes));
        idle(2, 1'b1);
        check({tag, "_fill0"}, 64'(FILL), 64'd0);
    endtask

    task automatic do_reset();
        RSTn             = 1'b0;
        SITCP_RX_WENB    = '0;
        OUT_READY        = 1'b0;
        USER_CLR         = 1'b0;
        SITCP_RX_CLR_ENB = 1'b0;
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, h0, needed;
        @(negedge clk);
        do_reset();

        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_d", OUT_D, 64'd0);
        check("rst_b", 64'(OUT_B), 64'd0);
        check("rst_radr", 64'(SITCP_RX_RADR), 64'd0);
        check("rst_clr_req", 64'(SITCP_RX_CLR_REQ), 64'd0);
        check("rst_fill", 64'(FILL), 64'd0);
        check("size", 64'(SITCP_RX_SIZE), 64'(SPACE));

        // Single full word: latency and content.
        step(8'hFF, 64'h0011223344556677, 1'b1);
        check("lat_e1", 64'(OUT_VALID), 64'd0);
        idle(1, 1'b1);
        check("lat_e2", 64'(OUT_VALID), 64'd0);
        idle(1, 1'b1);
        check("lat_e3_pre", 64'(OUT_VALID), 64'd0);
        idle(1, 1'b1);
        check("lat_e3", 64'(OUT_VALID), 64'd1);
        check("w1_d", OUT_D, 64'h0011223344556677);
        check("w1_b", 64'(OUT_B), 64'd8);
        idle(4, 1'b1);
        check("w1_radr", 64'(SITCP_RX_RADR), 64'h8);
        check("w1_fill", 64'(FILL), 64'd0);
        check("w1_valid_low", 64'(OUT_VALID), 64'd0);

        // Partial word followed by its remainder.
        do_reset();
        step(8'hE0, {$urandom, $urandom}, 1'b1);
        step(8'h1F, {$urandom, $urandom}, 1'b1);
        idle(8, 1'b1);
        check("split_count", 64'(b_hist.size()), 64'd2);
        if (b_hist.size() >= 2) begin
            check("split_b0", 64'(b_hist[0]), 64'd3);
            check("split_b1", 64'(b_hist[1]), 64'd5);
        end
        check("split_radr", 64'(SITCP_RX_RADR), 64'h8);

        // Random stream with random back-pressure; wraps the buffer twice.
        do_reset();
        c = 0;
        while (wr_bytes < 4096 * 8 && c < 60000) begin
            if ($urandom_range(0, 3) != 0 && room() > 0)
                wr_step($urandom_range(0, 1) ? 8 : int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
            else
                idle(1, 1'($urandom_range(0, 1)));
            c++;
        end
        check("stream_written", 64'(wr_bytes >= 4096 * 8), 64'd1);
        drain("stream_drain", 4000, 1'b1);

        // Fill the buffer to its advertised size with the reader stalled.
        c = 0;
        while (room() > 0 && c < 4000) begin
            wr_step(8, 1'b0);
            c++;
        end
        idle(4, 1'b0);
        check("fill_full", 64'(FILL), 64'(SPACE));
        drain("full_drain", 5000, 1'b0);

        // Steer the write pointer to just below the wrap, then stream across it.
        c = 0;
        needed = (16'h3FF0 - wa) & AMASK;
        while (needed > 0 && c < 6000) begin
            wr_step(needed < 8 ? needed : 8, 1'b1);
            needed = (16'h3FF0 - wa) & AMASK;
            c++;
        end
        drain("pre_wrap_drain", 100, 1'b0);
        check("pre_wrap_radr", 64'(SITCP_RX_RADR), 64'h3FF0);
        h0 = b_hist.size();
        for (int i = 0; i < 4; i++) wr_step(8, 1'b1);
        idle(4, 1'b1);
        check("throughput", 64'(b_hist.size() - h0), 64'd4);
        drain("wrap_drain", 100, 1'b0);
        check("wrap_radr", 64'(SITCP_RX_RADR), 64'h0010);

`ifdef SITCPXG_RXRD_CLR_EN
        do_reset();
        for (int i = 0; i < 5; i++) wr_step(8, 1'b0);
        idle(4, 1'b0);
        check("clr_fill40", 64'(FILL), 64'd40);
        USER_CLR = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle(1, 1'b0);
            check("clr_wait_req", 64'(SITCP_RX_CLR_REQ), 64'd0);
        end
        check("clr_wait_valid", 64'(OUT_VALID), 64'd1);
        USER_CLR         = 1'b0;
        SITCP_RX_CLR_ENB = 1'b1;
        c = 0;
        while (!SITCP_RX_CLR_REQ && c < 5) begin
            @(negedge clk);
            c++;
        end
        check("clr_req_seen", 64'(SITCP_RX_CLR_REQ), 64'd1);
        SITCP_RX_CLR_ENB = 1'b0;
        @(negedge clk);
        check("clr_req_pulse", 64'(SITCP_RX_CLR_REQ), 64'd0);
        check("clr_fill", 64'(FILL), 64'd0);
        check("clr_radr", 64'(SITCP_RX_RADR), 64'd0);
        check("clr_valid", 64'(OUT_VALID), 64'd0);
        model_reset();
        wr_step(8, 1'b1);
        drain("post_clr_drain", 20, 1'b0);
        check("post_clr_radr", 64'(SITCP_RX_RADR), 64'h8);
`else
        do_reset();
        wr_step(8, 1'b1);
        USER_CLR         = 1'b1;
        SITCP_RX_CLR_ENB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b1);
            check("noclr_req", 64'(SITCP_RX_CLR_REQ), 64'd0);
        end
        USER_CLR         = 1'b0;
        SITCP_RX_CLR_ENB = 1'b0;
        drain("noclr_drain", 20, 1'b0);
        check("noclr_radr", 64'(SITCP_RX_RADR), 64'h8);
`endif

        // Reset while a word is presented.
        do_reset();
        for (int i = 0; i < 3; i++) wr_step(8, 1'b0);
        idle(4, 1'b0);
        check("mid_valid_before", 64'(OUT_VALID), 64'd1);
        RSTn      = 1'b0;
        OUT_READY = 1'b0;
        SITCP_RX_WENB = '0;
        @(negedge clk);
        RSTn = 1'b1;
        check("mid_rst_valid", 64'(OUT_VALID), 64'd0);
        check("mid_rst_d", OUT_D, 64'd0);
        check("mid_rst_b", 64'(OUT_B), 64'd0);
        check("mid_rst_radr", 64'(SITCP_RX_RADR), 64'd0);
        check("mid_rst_fill", 64'(FILL), 64'd0);
        check("mid_rst_req", 64'(SITCP_RX_CLR_REQ), 64'd0);
        model_reset();
        wr_step(8, 1'b1);
        drain("post_rst_drain", 20, 1'b0);
        check("post_rst_radr", 64'(SITCP_RX_RADR), 64'h8);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/sitcpxg_rx_buf_reader.md
# sitcpxg_rx_buf_reader

Receive-side consumer of the SiTCPXG user RX buffer interface. Owns the RX buffer RAM: accepts SiTCP's byte-enabled big-endian writes, tracks the write end, and streams received bytes to user logic as left-justified 64-bit words with a byte count. Returns the consumed byte address to SiTCP so the TCP window reopens. Sits between the SiTCPXG core and the user's TCP receive datapath, all on the XGMII clock.

## Interface
Parameters:
- ADDR_W, 14: buffer byte-address width; RAM depth 2^(ADDR_W-3) x 64 bits; legal range 12..16.

Ports:
- XGMII_CLOCK  in  1  sole clock.
- RSTn  in  1  synchronous, active-low reset.
- SITCP_RX_WADR  in  16  SiTCP write byte address; bits [ADDR_W-1:3] select the word.
- SITCP_RX_WENB  in  8  byte write enables; bit 7 = byte 0 (lane [63:56]).
- SITCP_RX_WDAT  in  64  write data, big endian.
- SITCP_RX_RADR  out  16  consumed byte pointer to SiTCP; upper unused bits 0.
- SITCP_RX_SIZE  out  16  constant 2^ADDR_W - 16.
- SITCP_RX_CLR_ENB  in  1  SiTCP permits buffer clear.
- SITCP_RX_CLR_REQ  out  1  clear request pulse to SiTCP.
- USER_CLR  in  1  user request to discard buffer contents.
- OUT_D  out  64  data; first valid byte in [63:56].
- OUT_B  out  4  valid byte count 1..8.
- OUT_VALID  out  1  OUT_D/OUT_B valid.
- OUT_READY  in  1  user accepts word.
- FILL  out  16  bytes written and not yet consumed.

## Operation
- Write side: any nonzero WENB writes enabled lanes to word WADR[ADDR_W-1:3]. wptr <= word_base + (index of lowest set WENB bit, counted from bit 7) + 1, registered one cycle after the RAM write. Enables are contiguous and in-order; non-contiguous patterns are outside contract.
- Pointers are ADDR_W bits, modulo 2^ADDR_W. avail = wptr - iptr (issue pointer); FILL = wptr - cptr (consumed pointer), zero-extended.
- Issue: when avail != 0 and the 2-entry output buffer has space (counting the entry leaving this cycle), read word iptr[ADDR_W-1:3]; n = min(8 - iptr[2:0], avail); iptr += n.
- Align: RAM output shifted left by 8*iptr[2:0] (issue-time value, pipelined); unused low lanes zero. OUT_B = n.
- Consume: on OUT_VALID && OUT_READY, cptr += OUT_B; SITCP_RX_RADR = cptr.
- State machine: RUN (normal), CLR_WAIT (USER_CLR seen, waiting CLR_ENB), CLR (one cycle: CLR_REQ=1, wptr/iptr/cptr <= 0, output buffer flushed, OUT_VALID <= 0), then RUN. No issue in CLR_WAIT/CLR; buffered words still drain in CLR_WAIT.
- USER_CLR with CLR_ENB already high: RUN -> CLR directly.

## Timing
- Reset (RSTn=0 at edge): OUT_VALID 0, OUT_D 0, OUT_B 0, SITCP_RX_RADR 0, SITCP_RX_CLR_REQ 0, FILL 0, all pointers 0, state RUN. SITCP_RX_SIZE constant throughout. Reset mid-stream drops buffered words without handshake.
- Latency: write edge t -> wptr update t+1 -> RAM read issue t+1 -> OUT_VALID high after edge t+3.
- Throughput: 1 word/cycle with OUT_READY held high and avail >= 8 at word-aligned iptr.
- OUT_D/OUT_B stable while OUT_VALID && !OUT_READY; OUT_VALID never drops without a handshake except in CLR or reset.
- Write into the word currently being read in the same cycle: bytes beyond old wptr are not in avail, so output is unaffected.
- Full: wptr = cptr + 2^ADDR_W - 16 max; SiTCP never exceeds SITCP_RX_SIZE.
- Wrap: pointers roll from 2^ADDR_W-1 to 0 with no gap; a word never straddles the wrap (word granularity).
- CLR wins over a simultaneous write or handshake in that cycle.

## Configuration
- SITCPXG_RXRD_CLR_EN defined: USER_CLR, CLR_WAIT/CLR states, and CLR_REQ as above.
- Undefined: USER_CLR and SITCP_RX_CLR_ENB ignored, SITCP_RX_CLR_REQ tied 0, FSM permanently RUN.

## Test plan
- Reset then single write WADR=0x0000, WENB=0xFF, WDAT=0x0011223344556677, READY=1 -> OUT_VALID 3 cycles later, OUT_D=0x0011223344556677, OUT_B=8, RADR=0x0008, FILL 0.
- Write WENB=0xE0 at 0x0000 then 0x1F at 0x0000 -> two words: OUT_B=3 then OUT_B=5 with bytes 3..7 at [63:24], RADR ends 0x0008.
- Stream 4096 words, READY toggled 50% random -> byte order intact, no duplication/loss, OUT_D stable while stalled, FILL never > 16368.
- Wrap at ADDR_W=14: write across 0x3FF8 -> 0x0000 -> RADR goes 0x3FF8, 0x0000 contiguous, data in order.
- With SITCPXG_RXRD_CLR_EN, 40 bytes pending, USER_CLR=1, CLR_ENB=0 for 10 cycles then 1 -> CLR_REQ single-cycle pulse, FILL=0, RADR=0, OUT_VALID=0 next cycle.
- RSTn=0 for one cycle while OUT_VALID=1 -> all outputs at reset values next cycle, first new write output with RADR counted from 0.
